// File: rtl/alu_arbiter_if.sv
// Requester/response bundle between two ALU clients, a result consumer and alu_arbiter.
// The master side drives the requests and resp_ready; the slave side is the arbiter.
interface alu_arbiter_if;
    logic       req0_valid;
    logic       req1_valid;
    logic [5:0] req0_x;
    logic [5:0] req0_y;
    logic [5:0] req1_x;
    logic [5:0] req1_y;
    logic [2:0] req0_fxn;
    logic [2:0] req1_fxn;
    logic       req0_ready;
    logic       req1_ready;
    logic       resp_valid;
    logic       resp_id;
    logic [5:0] resp_answer;
    logic       resp_carry;
    logic       resp_oflow;
    logic       resp_ready;
    logic       busy;

    modport master (
        output req0_valid, req1_valid, req0_x, req0_y, req1_x, req1_y,
        output req0_fxn, req1_fxn, resp_ready,
        input  req0_ready, req1_ready, resp_valid, resp_id, resp_answer,
        input  resp_carry, resp_oflow, busy
    );

    modport slave (
        input  req0_valid, req1_valid, req0_x, req0_y, req1_x, req1_y,
        input  req0_fxn, req1_fxn, resp_ready,
        output req0_ready, req1_ready, resp_valid, resp_id, resp_answer,
        output resp_carry, resp_oflow, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end around a 6-bit ALU: one operation in
// flight, grant in IDLE, compute in EXEC, hold the registered result in RESP.
module alu_module (
    input  logic [5:0] i_x,
    input  logic [5:0] i_y,
    input  logic [3:0] i_fxn,
    output logic [5:0] o_answer,
    output logic       o_carry,
    output logic       o_oflow
);
    logic [6:0] w_sum;
    logic [6:0] w_diff;
    logic [6:0] w_neg_x;
    logic [6:0] w_neg_y;
    logic [5:0] w_xnor;
    logic       w_lt;

    // Subtraction and negation are two's-complement adds; carry means "no borrow".
    assign w_sum   = {1'b0, i_x} + {1'b0, i_y};
    assign w_diff  = {1'b0, i_x} + {1'b0, ~i_y} + 7'd1;
    assign w_neg_x = {1'b0, ~i_x} + 7'd1;
    assign w_neg_y = {1'b0, ~i_y} + 7'd1;
    assign w_lt    = $signed(i_x) < $signed(i_y);

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_xnor
            assign w_xnor[gi] = ~(i_x[gi] ^ i_y[gi]);
        end
    endgenerate

    always_comb begin
        o_answer = 6'd0;
        o_carry  = 1'b0;
        o_oflow  = 1'b0;
        case (i_fxn)
            4'd0: o_answer = i_x;
            4'd1: o_answer = i_y;
            4'd2: begin
                o_answer = w_neg_x[5:0];
                o_carry  = w_neg_x[6];
                o_oflow  = (i_x == 6'b100000);
            end
            4'd3: begin
                o_answer = w_neg_y[5:0];
                o_carry  = w_neg_y[6];
                o_oflow  = (i_y == 6'b100000);
            end
            4'd4: o_answer = {5'd0, w_lt};
            4'd5: o_answer = w_xnor;
            4'd6: begin
                o_answer = w_sum[5:0];
                o_carry  = w_sum[6];
                o_oflow  = (i_x[5] == i_y[5]) && (w_sum[5] != i_x[5]);
            end
            4'd7: begin
                o_answer = w_diff[5:0];
                o_carry  = w_diff[6];
                o_oflow  = (i_x[5] != i_y[5]) && (w_diff[5] != i_x[5]);
            end
            default: begin
                o_answer = 6'd0;
                o_carry  = 1'b0;
                o_oflow  = 1'b0;
            end
        endcase
    end
endmodule

module alu_arbiter (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_ptr;
    logic [5:0] r_x;
    logic [5:0] r_y;
    logic [2:0] r_fxn;
    logic       r_id;
    logic       r_resp_id;
    logic [5:0] r_resp_answer;
    logic       r_resp_carry;
    logic       r_resp_oflow;
    logic       w_grant0;
    logic       w_grant1;
    logic [5:0] w_alu_answer;
    logic       w_alu_carry;
    logic       w_alu_oflow;

    // Pointer only matters on contention; a lone requester always wins.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!rst && r_state == ST_IDLE) begin
            if (bus.req0_valid && (!bus.req1_valid || !r_ptr)) begin
                w_grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                w_grant1 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant0 || w_grant1) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: w_state_next = ST_RESP;
            ST_RESP: begin
                if (bus.resp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready  = w_grant0;
        bus.req1_ready  = w_grant1;
        bus.resp_valid  = (r_state == ST_RESP);
        bus.busy        = (r_state != ST_IDLE);
        bus.resp_id     = r_resp_id;
        bus.resp_answer = r_resp_answer;
        bus.resp_carry  = r_resp_carry;
        bus.resp_oflow  = r_resp_oflow;
    end

    // Operands move only on a grant, so the ALU sees stable inputs through EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr         <= 1'b0;
            r_x           <= 6'd0;
            r_y           <= 6'd0;
            r_fxn         <= 3'd0;
            r_id          <= 1'b0;
            r_resp_id     <= 1'b0;
            r_resp_answer <= 6'd0;
            r_resp_carry  <= 1'b0;
            r_resp_oflow  <= 1'b0;
        end else begin
            if (w_grant0) begin
                r_x   <= bus.req0_x;
                r_y   <= bus.req0_y;
                r_fxn <= bus.req0_fxn;
                r_id  <= 1'b0;
                r_ptr <= 1'b1;
            end else if (w_grant1) begin
                r_x   <= bus.req1_x;
                r_y   <= bus.req1_y;
                r_fxn <= bus.req1_fxn;
                r_id  <= 1'b1;
                r_ptr <= 1'b0;
            end
            if (r_state == ST_EXEC) begin
                r_resp_id     <= r_id;
                r_resp_answer <= w_alu_answer;
                r_resp_carry  <= w_alu_carry;
                r_resp_oflow  <= w_alu_oflow;
            end
        end
    end

    alu_module u_alu (
        .i_x      (r_x),
        .i_y      (r_y),
        .i_fxn    ({1'b0, r_fxn}),
        .o_answer (w_alu_answer),
        .o_carry  (w_alu_carry),
        .o_oflow  (w_alu_oflow)
    );
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if bus();

    alu_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: at most one pending operation, granted in cycle p_cyc.
    bit         m_known = 1'b0;
    bit         m_busy  = 1'b0;
    bit         m_ptr   = 1'b0;
    bit         p_id;
    logic [5:0] p_x;
    logic [5:0] p_y;
    logic [2:0] p_f;
    int         p_cyc   = 0;
    int         cyc     = 0;
    bit         g0      = 1'b0;
    bit         g1      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Returns {oflow, carry, answer[5:0]} from plain integer arithmetic.
    function automatic logic [7:0] alu_ref(input logic [2:0] f, input logic [5:0] x, input logic [5:0] y);
        int sx, sy, r;
        logic [5:0] a;
        logic c, o;
        sx = $signed(x);
        sy = $signed(y);
        a = 6'd0; c = 1'b0; o = 1'b0;
        case (f)
            3'd0: a = x;
            3'd1: a = y;
            3'd2: begin r = -sx; a = r[5:0]; c = (x == 0); o = (r > 31); end
            3'd3: begin r = -sy; a = r[5:0]; c = (y == 0); o = (r > 31); end
            3'd4: a = (sx < sy) ? 6'd1 : 6'd0;
            3'd5: a = ~(x ^ y);
            3'd6: begin
                r = int'(x) + int'(y); a = r[5:0]; c = (r > 63);
                r = sx + sy; o = (r > 31) || (r < -32);
            end
            default: begin
                r = int'(x) - int'(y); a = r[5:0]; c = (x >= y);
                r = sx - sy; o = (r > 31) || (r < -32);
            end
        endcase
        return {o, c, a};
    endfunction

    task automatic sample();
        logic [7:0] r;
        bit ev;
        @(negedge clk);
        g0 = m_known && !rst && !m_busy && bus.req0_valid && (!bus.req1_valid || !m_ptr);
        g1 = m_known && !rst && !m_busy && bus.req1_valid && (!bus.req0_valid || m_ptr);
        if (m_known) begin
            ev = m_busy && (cyc >= p_cyc + 2);
            chk("req0_ready", bus.req0_ready, g0);
            chk("req1_ready", bus.req1_ready, g1);
            chk("busy", bus.busy, m_busy);
            chk("resp_valid", bus.resp_valid, ev);
            if (ev) begin
                r = alu_ref(p_f, p_x, p_y);
                chk("resp_id", bus.resp_id, p_id);
                chk("resp_answer", bus.resp_answer, r[5:0]);
                chk("resp_carry", bus.resp_carry, r[6]);
                chk("resp_oflow", bus.resp_oflow, r[7]);
            end
        end
    endtask

    task automatic step();
        sample();
        @(posedge clk);
        if (rst) begin
            m_known = 1'b1;
            m_busy  = 1'b0;
            m_ptr   = 1'b0;
        end else if (m_known) begin
            if (m_busy) begin
                if (cyc >= p_cyc + 2 && bus.resp_ready) begin
                    m_busy = 1'b0;
                    $display("txn id=%0d fxn=%0d x=%0h y=%0h answer=%0h", p_id, p_f, p_x, p_y,
                             bus.resp_answer);
                end
            end else if (g0 || g1) begin
                m_busy = 1'b1;
                p_id   = g1;
                p_x    = g1 ? bus.req1_x : bus.req0_x;
                p_y    = g1 ? bus.req1_y : bus.req0_y;
                p_f    = g1 ? bus.req1_fxn : bus.req0_fxn;
                p_cyc  = cyc;
                m_ptr  = g0;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_req0(input bit v, input logic [5:0] x, input logic [5:0] y, input logic [2:0] f);
        bus.req0_valid = v; bus.req0_x = x; bus.req0_y = y; bus.req0_fxn = f;
    endtask

    task automatic set_req1(input bit v, input logic [5:0] x, input logic [5:0] y, input logic [2:0] f);
        bus.req1_valid = v; bus.req1_x = x; bus.req1_y = y; bus.req1_fxn = f;
    endtask

    initial begin
        int ids[$];
        int gcyc[$];
        rst = 1'b1;
        set_req0(1'b0, 6'd0, 6'd0, 3'd0);
        set_req1(1'b0, 6'd0, 6'd0, 3'd0);
        bus.resp_ready = 1'b1;

        // Reset state
        reset_dut();
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_resp_answer", bus.resp_answer, 6'd0);
        chk("rst_resp_id", bus.resp_id, 1'b0);
        chk("rst_flags", {bus.resp_carry, bus.resp_oflow}, 2'b00);

        // 5 + 3 from req0, fixed two-cycle latency
        set_req0(1'b1, 6'd5, 6'd3, 3'b110);
        #1;
        chk("add_ready0", {bus.req0_ready, bus.req1_ready}, 2'b10);
        step();
        bus.req0_valid = 1'b0;
        #1;
        chk("add_n1_valid", bus.resp_valid, 1'b0);
        step();
        #1;
        chk("add_n2_valid", bus.resp_valid, 1'b1);
        chk("add_answer", bus.resp_answer, 6'd8);
        chk("add_cf_id", {bus.resp_carry, bus.resp_oflow, bus.resp_id}, 3'b000);
        step();

        // Contention after reset: req0 first, then req1
        reset_dut();
        set_req0(1'b1, 6'd3, 6'd5, 3'b111);
        set_req1(1'b1, 6'd9, 6'd9, 3'b101);
        #1;
        chk("cont_ready", {bus.req0_ready, bus.req1_ready}, 2'b10);
        step();
        bus.req0_valid = 1'b0;
        step();
        #1;
        chk("sub_answer", bus.resp_answer, 6'b111110);
        chk("sub_carry_id", {bus.resp_carry, bus.resp_id}, 2'b00);
        step();
        #1;
        chk("cont_ready1", {bus.req0_ready, bus.req1_ready}, 2'b01);
        step();
        bus.req1_valid = 1'b0;
        step();
        #1;
        chk("xnor_answer", bus.resp_answer, 6'b111111);
        chk("xnor_id", bus.resp_id, 1'b1);
        step();

        // Six back-to-back operations with both requesters always valid
        reset_dut();
        set_req0(1'b1, 6'($urandom), 6'($urandom), 3'($urandom));
        set_req1(1'b1, 6'($urandom), 6'($urandom), 3'($urandom));
        for (int i = 0; i < 18; i++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) gcyc.push_back(i);
            if (bus.resp_valid) ids.push_back(int'(bus.resp_id));
            step();
            if (g0) set_req0(1'b1, 6'($urandom), 6'($urandom), 3'($urandom));
            if (g1) set_req1(1'b1, 6'($urandom), 6'($urandom), 3'($urandom));
        end
        chk("b2b_resp_count", ids.size(), 6);
        chk("b2b_grant_count", gcyc.size(), 6);
        foreach (ids[i]) chk("b2b_id_seq", ids[i], i % 2);
        for (int i = 1; i < gcyc.size(); i++) chk("b2b_interval", gcyc[i] - gcyc[i-1], 3);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();

        // Back-pressure: 31 + 1 held for 5 cycles
        reset_dut();
        set_req1(1'b1, 6'd31, 6'd1, 3'b110);
        bus.resp_ready = 1'b0;
        step();
        set_req1(1'b0, 6'd0, 6'd0, 3'd0);
        set_req0(1'b1, 6'd7, 6'd2, 3'b111);
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_answer", bus.resp_answer, 6'b100000);
            chk("hold_oflow_id", {bus.resp_oflow, bus.resp_id}, 2'b11);
            chk("hold_busy_rdy", {bus.busy, bus.req0_ready, bus.req1_ready}, 3'b100);
            step();
        end
        bus.resp_ready = 1'b1;
        step();
        #1;
        chk("hold_idle", {bus.busy, bus.resp_valid}, 2'b00);
        step();
        bus.req0_valid = 1'b0;
        step();
        step();

        // Reset during EXEC discards the operation and clears the pointer
        reset_dut();
        set_req0(1'b1, 6'd10, 6'd4, 3'b110);
        step();
        bus.req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_exec_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        step();
        rst = 1'b0;
        #1;
        chk("rst_exec_idle", {bus.busy, bus.resp_valid}, 2'b00);
        chk("rst_exec_answer", bus.resp_answer, 6'd0);
        set_req0(1'b1, 6'd1, 6'd2, 3'b000);
        set_req1(1'b1, 6'd3, 6'd4, 3'b001);
        #1;
        chk("rst_exec_ptr", {bus.req0_ready, bus.req1_ready}, 2'b10);

        // Signed compare -2 < 1
        reset_dut();
        set_req0(1'b1, 6'b111110, 6'd1, 3'b100);
        step();
        bus.req0_valid = 1'b0;
        step();
        #1;
        chk("slt_answer", bus.resp_answer, 6'b000001);
        chk("slt_flags", {bus.resp_carry, bus.resp_oflow}, 2'b00);
        step();

        // Randomized traffic with withdrawals, back-pressure and occasional reset
        for (int i = 0; i < 4000; i++) begin
            step();
            rst = ($urandom_range(0, 149) == 0);
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            if (g0 || !bus.req0_valid)
                set_req0($urandom_range(0, 2) == 0 ? 1'b1 : (g0 ? 1'b1 : 1'b0),
                         6'($urandom), 6'($urandom), 3'($urandom));
            else if ($urandom_range(0, 19) == 0)
                bus.req0_valid = 1'b0;
            if (g1 || !bus.req1_valid)
                set_req1($urandom_range(0, 2) == 0 ? 1'b1 : (g1 ? 1'b1 : 1'b0),
                         6'($urandom), 6'($urandom), 3'($urandom));
            else if ($urandom_range(0, 19) == 0)
                bus.req1_valid = 1'b0;
        end
        rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
